// File: rtl/tile_mem_l15_bridge_pkg.sv
// Shared encodings and helpers for the multi-initiator L1.5 bridge.
package tile_l15_pkg;

    localparam int PHY_ADDR_WIDTH = 40;

    typedef enum logic [4:0] {
        LOAD_RQ  = 5'd0,
        STORE_RQ = 5'd1
    } rqtype_e;

    typedef enum logic [3:0] {
        LOAD_RET = 4'd0,
        ST_ACK   = 4'd4
    } rettype_e;

    typedef enum logic [2:0] {
        SIZE_1B = 3'd1,
        SIZE_2B = 3'd2,
        SIZE_4B = 3'd3
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        REQ,
        WAIT,
        DONE
    } state_e;

    typedef struct packed {
        logic       legal;
        logic       load;
        size_e      size;
        logic [1:0] offset;
    } strb_dec_t;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Only naturally aligned 1/2/4-byte accesses map onto an L1.5 size.
    function automatic strb_dec_t decode_strb(input logic [3:0] s);
        strb_dec_t d;
        d.legal  = 1'b1;
        d.load   = (s == 4'b0000);
        d.size   = SIZE_4B;
        d.offset = 2'd0;
        case (s)
            4'b0000, 4'b1111: d.offset = 2'd0;
            4'b0011: d.size = SIZE_2B;
            4'b1100: begin d.size = SIZE_2B; d.offset = 2'd2; end
            4'b0001: d.size = SIZE_1B;
            4'b0010: begin d.size = SIZE_1B; d.offset = 2'd1; end
            4'b0100: begin d.size = SIZE_1B; d.offset = 2'd2; end
            4'b1000: begin d.size = SIZE_1B; d.offset = 2'd3; end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/tile_mem_l15_bridge_if.sv
// L1.5 transducer request/response channel; master is the bridge side.
interface tile_mem_l15_bridge_if;
    import tile_l15_pkg::*;

    logic                      transducer_l15_val;
    logic [4:0]                transducer_l15_rqtype;
    logic [2:0]                transducer_l15_size;
    logic [PHY_ADDR_WIDTH-1:0] transducer_l15_address;
    logic [63:0]               transducer_l15_data;
    logic                      transducer_l15_nc;
    logic                      transducer_l15_threadid;
    logic                      transducer_l15_prefetch;
    logic                      transducer_l15_invalidate_cacheline;
    logic                      transducer_l15_blockstore;
    logic                      transducer_l15_blockinitstore;
    logic [1:0]                transducer_l15_l1rplway;
    logic [63:0]               transducer_l15_data_next_entry;
    logic [32:0]               transducer_l15_csm_data;
    logic [3:0]                transducer_l15_amo_op;
    logic                      l15_transducer_ack;
    logic                      l15_transducer_val;
    logic [3:0]                l15_transducer_returntype;
    logic [63:0]               l15_transducer_data_0;
    logic                      transducer_l15_req_ack;

    modport master (
        output transducer_l15_val, transducer_l15_rqtype, transducer_l15_size,
               transducer_l15_address, transducer_l15_data, transducer_l15_nc,
               transducer_l15_threadid, transducer_l15_prefetch,
               transducer_l15_invalidate_cacheline, transducer_l15_blockstore,
               transducer_l15_blockinitstore, transducer_l15_l1rplway,
               transducer_l15_data_next_entry, transducer_l15_csm_data,
               transducer_l15_amo_op, transducer_l15_req_ack,
        input  l15_transducer_ack, l15_transducer_val, l15_transducer_returntype,
               l15_transducer_data_0
    );

    modport slave (
        input  transducer_l15_val, transducer_l15_rqtype, transducer_l15_size,
               transducer_l15_address, transducer_l15_data, transducer_l15_nc,
               transducer_l15_threadid, transducer_l15_prefetch,
               transducer_l15_invalidate_cacheline, transducer_l15_blockstore,
               transducer_l15_blockinitstore, transducer_l15_l1rplway,
               transducer_l15_data_next_entry, transducer_l15_csm_data,
               transducer_l15_amo_op, transducer_l15_req_ack,
        output l15_transducer_ack, l15_transducer_val, l15_transducer_returntype,
               l15_transducer_data_0
    );

endinterface

// File: rtl/tile_mem_l15_bridge_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = IW'((int'(ptr) + i) % N);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/tile_mem_l15_bridge.sv
// Arbitrates several valid/ready memory initiators onto one L1.5 channel,
// one request outstanding at a time.
module tile_mem_l15_bridge
    import tile_l15_pkg::*;
#(
    parameter int                    NUM_PORTS  = 2,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] NC_BASE    = 32'hF000_0000,
    parameter logic [ADDR_WIDTH-1:0] NC_MASK    = 32'hF000_0000
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            mem_valid,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] mem_addr,
    input  logic [NUM_PORTS*32-1:0]         mem_wdata,
    input  logic [NUM_PORTS*4-1:0]          mem_wstrb,
    output logic [NUM_PORTS-1:0]            mem_ready,
    output logic [31:0]                     mem_rdata,
    output logic [NUM_PORTS-1:0]            mem_err,
    tile_mem_l15_bridge_if.master           l15
);

    localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    state_e                 state;
    logic [IW-1:0]          rr_ptr;
    logic [IW-1:0]          gnt_idx;
    logic [NUM_PORTS-1:0]   lat_grant;
    logic [ADDR_WIDTH-1:0]  lat_addr;
    logic [31:0]            lat_wdata;
    logic [3:0]             lat_wstrb;
    logic [NUM_PORTS-1:0]   arb_grant;
    logic [IW-1:0]          arb_idx;
    logic                   arb_any;
    strb_dec_t              dec;
    logic [31:0]            resp_word;
    logic                   resp_match;

    rr_arbiter #(.N(NUM_PORTS)) u_arb (
        .req   (mem_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign dec        = decode_strb(lat_wstrb);
    assign resp_word  = lat_addr[2] ? l15.l15_transducer_data_0[31:0]
                                    : l15.l15_transducer_data_0[63:32];
    assign resp_match = dec.load ? (l15.l15_transducer_returntype == LOAD_RET)
                                 : (l15.l15_transducer_returntype == ST_ACK);

    // Every response, solicited or not, is consumed in the cycle it arrives.
    assign l15.transducer_l15_req_ack              = l15.l15_transducer_val & ~reset;
    assign l15.transducer_l15_threadid             = 1'b0;
    assign l15.transducer_l15_prefetch             = 1'b0;
    assign l15.transducer_l15_invalidate_cacheline = 1'b0;
    assign l15.transducer_l15_blockstore           = 1'b0;
    assign l15.transducer_l15_blockinitstore       = 1'b0;
    assign l15.transducer_l15_l1rplway             = 2'd0;
    assign l15.transducer_l15_data_next_entry      = 64'd0;
    assign l15.transducer_l15_csm_data             = 33'd0;
    assign l15.transducer_l15_amo_op               = 4'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state                      <= IDLE;
            rr_ptr                     <= '0;
            gnt_idx                    <= '0;
            lat_grant                  <= '0;
            lat_addr                   <= '0;
            lat_wdata                  <= '0;
            lat_wstrb                  <= '0;
            mem_ready                  <= '0;
            mem_rdata                  <= '0;
            mem_err                    <= '0;
            l15.transducer_l15_val     <= 1'b0;
            l15.transducer_l15_rqtype  <= '0;
            l15.transducer_l15_size    <= '0;
            l15.transducer_l15_address <= '0;
            l15.transducer_l15_data    <= '0;
            l15.transducer_l15_nc      <= 1'b0;
        end else begin
            mem_ready <= '0;
            unique case (state)
                IDLE: begin
                    if (arb_any) begin
                        gnt_idx   <= arb_idx;
                        lat_grant <= arb_grant;
                        lat_addr  <= mem_addr[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                        lat_wdata <= mem_wdata[int'(arb_idx)*32 +: 32];
                        lat_wstrb <= mem_wstrb[int'(arb_idx)*4 +: 4];
                        state     <= DECODE;
                    end
                end
                DECODE: begin
                    if (dec.legal) begin
                        l15.transducer_l15_val     <= 1'b1;
                        l15.transducer_l15_rqtype  <= dec.load ? LOAD_RQ : STORE_RQ;
                        l15.transducer_l15_size    <= dec.size;
                        l15.transducer_l15_address <=
                            PHY_ADDR_WIDTH'({lat_addr[ADDR_WIDTH-1:2], dec.offset});
                        l15.transducer_l15_data    <= {2{bswap32(lat_wdata)}};
                        l15.transducer_l15_nc      <= ((lat_addr & NC_MASK) == NC_BASE);
                        state                      <= REQ;
                    end else begin
                        // Illegal strobes complete locally and never reach the L1.5.
                        mem_err   <= mem_err | lat_grant;
                        mem_ready <= lat_grant;
                        mem_rdata <= '0;
                        state     <= DONE;
                    end
                end
                REQ: begin
                    if (l15.l15_transducer_ack) begin
                        l15.transducer_l15_val <= 1'b0;
                        state                  <= WAIT;
                    end
                end
                WAIT: begin
                    if (l15.l15_transducer_val && resp_match) begin
                        mem_rdata <= dec.load ? bswap32(resp_word) : 32'd0;
                        mem_ready <= lat_grant;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    rr_ptr <= (gnt_idx == IW'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_mem_l15_bridge.sv
// Scoreboard bench: expected L1.5 requests and completions are queued at drive time.
module tb_tile_mem_l15_bridge;

    localparam int NP = 2;
    localparam int AW = 32;

    typedef struct {
        int          port;
        bit          legal;
        logic [4:0]  rqtype;
        logic [2:0]  size;
        logic [39:0] address;
        logic [63:0] data;
        logic        nc;
        logic [63:0] resp;
        logic [31:0] rdata;
        bit          checkData;
        bit          unsol;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [NP-1:0]    mem_valid;
    logic [NP*AW-1:0] mem_addr;
    logic [NP*32-1:0] mem_wdata;
    logic [NP*4-1:0]  mem_wstrb;
    logic [NP-1:0]    mem_ready;
    logic [31:0]      mem_rdata;
    logic [NP-1:0]    mem_err;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   driveCyc = 0;
    bit   latArm = 1'b0;
    bit   holdResp = 1'b0;
    int   heldCount = 0;
    int   lateReq = 0;
    int   lateServed = 0;
    exp_t reqQ[$];
    exp_t doneQ[$];

    tile_mem_l15_bridge_if l15 ();

    tile_mem_l15_bridge #(
        .NUM_PORTS  (NP),
        .ADDR_WIDTH (AW),
        .NC_BASE    (32'hF000_0000),
        .NC_MASK    (32'hF000_0000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .mem_err   (mem_err),
        .l15       (l15)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] swapBytes(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic exp_t makeExp(input int p, input logic [31:0] addr, input logic [31:0] wdata,
                                     input logic [3:0] wstrb, input logic [63:0] resp, input bit unsol);
        exp_t        e;
        logic [1:0]  off;
        logic [31:0] half;
        e.port  = p;
        e.legal = 1'b1;
        e.size  = 3'd3;
        off     = 2'd0;
        case (wstrb)
            4'b0000, 4'b1111: off = 2'd0;
            4'b0011: e.size = 3'd2;
            4'b1100: begin e.size = 3'd2; off = 2'd2; end
            4'b0001: e.size = 3'd1;
            4'b0010: begin e.size = 3'd1; off = 2'd1; end
            4'b0100: begin e.size = 3'd1; off = 2'd2; end
            4'b1000: begin e.size = 3'd1; off = 2'd3; end
            default: e.legal = 1'b0;
        endcase
        e.rqtype    = (wstrb == 4'b0000) ? 5'd0 : 5'd1;
        e.address   = {8'h00, addr[31:2], off};
        e.data      = {swapBytes(wdata), swapBytes(wdata)};
        e.nc        = (addr[31:28] == 4'hF);
        half        = addr[2] ? resp[31:0] : resp[63:32];
        e.rdata     = (e.legal && wstrb == 4'b0000) ? swapBytes(half) : 32'h0;
        e.checkData = !e.legal || (wstrb == 4'b0000);
        e.resp      = resp;
        e.unsol     = unsol;
        return e;
    endfunction

    task automatic driveSlot(input int p, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
        mem_addr[p*AW +: AW]  = addr;
        mem_wdata[p*32 +: 32] = wdata;
        mem_wstrb[p*4 +: 4]   = wstrb;
    endtask

    task automatic applyStimulus(input int p, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] wstrb, input logic [63:0] resp, input bit unsol);
        exp_t e;
        bit   done;
        @(negedge clk);
        e = makeExp(p, addr, wdata, wstrb, resp, unsol);
        if (e.legal) reqQ.push_back(e);
        doneQ.push_back(e);
        driveSlot(p, addr, wdata, wstrb);
        driveCyc     = cyc;
        latArm       = 1'b1;
        mem_valid[p] = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (mem_ready[p]) done = 1'b1;
        end
        if (!done) checkOutput("completion_timeout", 64'(done), 64'd1);
        mem_valid[p] = 1'b0;
    endtask

    task automatic applyPairs();
        logic [31:0] pa[2][3];
        logic [31:0] pw[2][3];
        logic [3:0]  ps[2][3];
        logic [63:0] pr[2][3];
        int          cnt[2];
        exp_t        e;
        pa[0] = '{32'h0000_0100, 32'h0000_0108, 32'h0000_010C};
        ps[0] = '{4'b1100, 4'b0000, 4'b0100};
        pa[1] = '{32'h0000_0200, 32'h0000_0204, 32'h0000_020B};
        ps[1] = '{4'b0000, 4'b0011, 4'b0001};
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < 3; k++) begin
                pw[p][k] = $urandom;
                pr[p][k] = {$urandom, $urandom};
            end
        @(negedge clk);
        latArm = 1'b0;
        for (int k = 0; k < 3; k++)
            for (int p = 0; p < 2; p++) begin
                e = makeExp(p, pa[p][k], pw[p][k], ps[p][k], pr[p][k], 1'b0);
                reqQ.push_back(e);
                doneQ.push_back(e);
            end
        cnt[0] = 0;
        cnt[1] = 0;
        for (int p = 0; p < 2; p++) driveSlot(p, pa[p][0], pw[p][0], ps[p][0]);
        mem_valid = 2'b11;
        for (int t = 0; t < 400 && (cnt[0] < 3 || cnt[1] < 3); t++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++)
                if (mem_ready[p]) begin
                    cnt[p]++;
                    if (cnt[p] < 3) driveSlot(p, pa[p][cnt[p]], pw[p][cnt[p]], ps[p][cnt[p]]);
                    else mem_valid[p] = 1'b0;
                end
        end
        checkOutput("pair_completions", 64'(cnt[0] + cnt[1]), 64'd6);
        mem_valid = '0;
    endtask

    // L1.5 model: checks each request against the queue, acks it, then answers.
    initial begin : responder
        exp_t e;
        int   d;
        l15.l15_transducer_ack        = 1'b0;
        l15.l15_transducer_val        = 1'b0;
        l15.l15_transducer_returntype = 4'd0;
        l15.l15_transducer_data_0     = 64'd0;
        forever begin
            @(negedge clk);
            if (lateReq != lateServed) begin
                l15.l15_transducer_val        = 1'b1;
                l15.l15_transducer_returntype = 4'd0;
                l15.l15_transducer_data_0     = {$urandom, $urandom};
                #1 checkOutput("late_req_ack", 64'(l15.transducer_l15_req_ack), 64'd1);
                @(negedge clk);
                l15.l15_transducer_val = 1'b0;
                checkOutput("late_no_ready", 64'(mem_ready), 64'd0);
                lateServed++;
            end else if (l15.transducer_l15_val && !reset) begin
                if (reqQ.size() == 0) begin
                    checkOutput("spurious_val", 64'(l15.transducer_l15_val), 64'd0);
                    l15.l15_transducer_ack = 1'b1;
                    @(negedge clk);
                    l15.l15_transducer_ack = 1'b0;
                end else begin
                    e = reqQ.pop_front();
                    if (latArm) checkOutput("idle_to_val", 64'(cyc - driveCyc), 64'd2);
                    checkOutput("rqtype", 64'(l15.transducer_l15_rqtype), 64'(e.rqtype));
                    checkOutput("size", 64'(l15.transducer_l15_size), 64'(e.size));
                    checkOutput("address", 64'(l15.transducer_l15_address), 64'(e.address));
                    if (e.rqtype == 5'd1) checkOutput("store_data", l15.transducer_l15_data, e.data);
                    checkOutput("nc", 64'(l15.transducer_l15_nc), 64'(e.nc));
                    d = $urandom_range(0, 2);
                    repeat (d) begin
                        @(negedge clk);
                        checkOutput("val_hold", 64'(l15.transducer_l15_val), 64'd1);
                    end
                    l15.l15_transducer_ack = 1'b1;
                    @(negedge clk);
                    l15.l15_transducer_ack = 1'b0;
                    checkOutput("val_drop", 64'(l15.transducer_l15_val), 64'd0);
                    if (holdResp) begin
                        heldCount++;
                    end else begin
                        if (e.unsol) begin
                            l15.l15_transducer_val        = 1'b1;
                            l15.l15_transducer_returntype = 4'd7;
                            l15.l15_transducer_data_0     = 64'hDEAD_BEEF_0BAD_F00D;
                            #1 checkOutput("unsol_req_ack", 64'(l15.transducer_l15_req_ack), 64'd1);
                            @(negedge clk);
                            l15.l15_transducer_val = 1'b0;
                            checkOutput("unsol_no_ready", 64'(mem_ready), 64'd0);
                        end
                        l15.l15_transducer_val        = 1'b1;
                        l15.l15_transducer_returntype = (e.rqtype == 5'd0) ? 4'd0 : 4'd4;
                        l15.l15_transducer_data_0     = e.resp;
                        #1 checkOutput("resp_req_ack", 64'(l15.transducer_l15_req_ack), 64'd1);
                        @(negedge clk);
                        l15.l15_transducer_val = 1'b0;
                        checkOutput("ready_latency", 64'(mem_ready[e.port]), 64'd1);
                    end
                end
            end
        end
    end

    initial begin : completionMonitor
        exp_t c;
        forever begin
            @(negedge clk);
            if (mem_ready != '0) begin
                if (doneQ.size() == 0) begin
                    checkOutput("unexpected_ready", 64'(mem_ready), 64'd0);
                end else begin
                    c = doneQ.pop_front();
                    checkOutput("ready_port", 64'(mem_ready), 64'(2'b01 << c.port));
                    if (c.checkData) checkOutput("rdata", 64'(mem_rdata), 64'(c.rdata));
                end
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        bit ok;
        reset     = 1'b1;
        mem_valid = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_val", 64'(l15.transducer_l15_val), 64'd0);
        checkOutput("reset_ready", 64'(mem_ready), 64'd0);
        checkOutput("reset_err", 64'(mem_err), 64'd0);
        checkOutput("reset_rdata", 64'(mem_rdata), 64'd0);
        checkOutput("reset_req_ack", 64'(l15.transducer_l15_req_ack), 64'd0);
        checkOutput("tieoffs", 64'(|{l15.transducer_l15_threadid, l15.transducer_l15_prefetch,
                                     l15.transducer_l15_invalidate_cacheline, l15.transducer_l15_blockstore,
                                     l15.transducer_l15_blockinitstore, l15.transducer_l15_l1rplway,
                                     l15.transducer_l15_data_next_entry, l15.transducer_l15_csm_data,
                                     l15.transducer_l15_amo_op}), 64'd0);
        reset = 1'b0;

        applyStimulus(0, 32'h0000_2000, 32'h0000_AB00, 4'b0010, 64'd0, 1'b0);
        applyStimulus(1, 32'h0000_1004, 32'h0, 4'b0000, 64'h1122_3344_5566_7788, 1'b0);
        applyPairs();

        applyStimulus(1, 32'h0000_3000, 32'h5555_5555, 4'b0101, 64'd0, 1'b0);
        checkOutput("err_set", 64'(mem_err), 64'd2);
        applyStimulus(0, 32'hF000_0010, 32'h0, 4'b0000, 64'hA1B2_C3D4_E5F6_0718, 1'b1);
        checkOutput("err_sticky", 64'(mem_err), 64'd2);

        holdResp = 1'b1;
        @(negedge clk);
        reqQ.push_back(makeExp(0, 32'h0000_6000, 32'h0, 4'b0000, 64'd0, 1'b0));
        driveSlot(0, 32'h0000_6000, 32'h0, 4'b0000);
        driveCyc     = cyc;
        latArm       = 1'b1;
        mem_valid[0] = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (heldCount > 0) ok = 1'b1;
        end
        checkOutput("held_request_acked", 64'(ok), 64'd1);
        repeat (2) @(negedge clk);
        reset        = 1'b1;
        mem_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("midreset_val", 64'(l15.transducer_l15_val), 64'd0);
        reset = 1'b0;
        checkOutput("err_cleared", 64'(mem_err), 64'd0);
        lateReq++;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (lateServed == lateReq) ok = 1'b1;
        end
        checkOutput("late_response_done", 64'(ok), 64'd1);
        holdResp = 1'b0;

        applyStimulus(1, 32'h0000_3008, 32'hCAFE_BABE, 4'b1111, 64'd0, 1'b0);
        applyStimulus(0, 32'h0000_4003, 32'h1234_5678, 4'b1000, 64'd0, 1'b0);
        applyStimulus(0, 32'h0000_5006, 32'h0, 4'b0000, 64'h0102_0304_0A0B_0C0D, 1'b0);

        repeat (5) @(negedge clk);
        checkOutput("queues_empty", 64'(reqQ.size() + doneQ.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
